// File: rtl/mul_seq_signed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_seq_signed
// Description : Sequential shift-add multiplier with per-transaction
//               signed/unsigned mode and valid/ready handshakes on both
//               the operand (upstream) and result (downstream) sides.
//               One multiplier bit is retired per BUSY cycle; the full
//               2*DATA_SIZE-bit product is presented in DONE.
//
// Ports       : clk          - clock, rising-edge active
//               rst_n        - asynchronous active-low reset
//               a_in         - multiplicand (DATA_SIZE bits)
//               b_in         - multiplier   (DATA_SIZE bits)
//               signed_in    - 1: operands are two's-complement, 0: unsigned
//               valid_f_in   - upstream operands valid
//               ready_f_in   - block can accept operands
//               valid_f_out  - result valid
//               result       - product (2*DATA_SIZE bits)
//               ready_f_out  - downstream ready
//
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_signed #(
  parameter int DATA_SIZE = 16,
  parameter int CNT_SIZE  = $clog2(DATA_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_SIZE-1:0]     a_in,
  input  logic [DATA_SIZE-1:0]     b_in,
  input  logic                     signed_in,
  input  logic                     valid_f_in,
  output logic                     ready_f_in,
  output logic                     valid_f_out,
  output logic [2*DATA_SIZE-1:0]   result,
  input  logic                     ready_f_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_SIZE-1:0] c_last_step = CNT_SIZE'(DATA_SIZE - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DATA_SIZE-1:0]     r_mcand;    // multiplicand magnitude
  logic [DATA_SIZE-1:0]     r_mplier;   // multiplier magnitude, shifts right; low product bits shift in at the top
  logic [DATA_SIZE-1:0]     r_upper;    // upper accumulator half
  logic [CNT_SIZE-1:0]      r_cnt;
  logic                     r_neg;
  logic [2*DATA_SIZE-1:0]   r_result;

  logic                     w_ready_in;
  logic                     w_valid_out;
  logic                     w_accept;
  logic                     w_last;
  logic [DATA_SIZE-1:0]     w_a_mag;
  logic [DATA_SIZE-1:0]     w_b_mag;
  logic [DATA_SIZE:0]       w_sum;
  logic [2*DATA_SIZE-1:0]   w_prod;

  // Magnitudes of the incoming operands. The most-negative value negates
  // to itself, which read as unsigned is exactly 2^(DATA_SIZE-1).
  assign w_a_mag = (signed_in & a_in[DATA_SIZE-1]) ? (~a_in + DATA_SIZE'(1)) : a_in;
  assign w_b_mag = (signed_in & b_in[DATA_SIZE-1]) ? (~b_in + DATA_SIZE'(1)) : b_in;

  assign w_last   = (r_cnt == c_last_step);
  assign w_accept = valid_f_in & w_ready_in;

  // One shift-add step: the carry is kept so the right shift of
  // {carry, upper, multiplier} loses nothing.
  assign w_sum  = {1'b0, r_upper} + (r_mplier[0] ? {1'b0, r_mcand} : {(DATA_SIZE+1){1'b0}});
  // Full unsigned product as it stands after the final step's shift.
  assign w_prod = {w_sum, r_mplier[DATA_SIZE-1:1]};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ready_in  = 1'b0;
    w_valid_out = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready_in = 1'b1;
        if (valid_f_in) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_valid_out = 1'b1;
        // Consuming the result frees the datapath in the same edge, so a
        // waiting operand pair goes straight to BUSY with no idle bubble.
        if (ready_f_out) begin
          w_ready_in  = 1'b1;
          w_state_nxt = valid_f_in ? ST_BUSY : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ready_f_in  = w_ready_in;
  assign valid_f_out = w_valid_out;
  assign result      = r_result;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_upper  <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_upper  <= '0;
      r_cnt    <= '0;
      r_neg    <= signed_in & (a_in[DATA_SIZE-1] ^ b_in[DATA_SIZE-1]);
    end else if (r_state == ST_BUSY) begin
      r_upper  <= w_sum[DATA_SIZE:1];
      r_mplier <= {w_sum[0], r_mplier[DATA_SIZE-1:1]};
      r_cnt    <= r_cnt + CNT_SIZE'(1);
      if (w_last) begin
        r_result <= r_neg ? (~w_prod + (2*DATA_SIZE)'(1)) : w_prod;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_signed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_signed
// Description : Self-checking bench for mul_seq_signed (DATA_SIZE=8).
//               A driver issues operands and pushes the expected product
//               into a scoreboard; a monitor pops and compares whenever a
//               result handshake completes, and checks the result latency.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_signed;

  localparam int DATA_SIZE = 8;
  localparam int LATENCY   = DATA_SIZE;
  localparam int SPACING   = DATA_SIZE + 1;
  localparam int TIMEOUT   = 200;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        signed_in;
  logic        valid_f_in;
  logic        ready_f_out;
  wire         ready_f_in;
  wire         valid_f_out;
  wire  [15:0] result;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  rand_rdy = 1'b0;
  logic  b2b_on   = 1'b0;
  item_t sb[$];

  mul_seq_signed #(.DATA_SIZE(DATA_SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .b_in        (b_in),
    .signed_in   (signed_in),
    .valid_f_in  (valid_f_in),
    .ready_f_in  (ready_f_in),
    .valid_f_out (valid_f_out),
    .result      (result),
    .ready_f_out (ready_f_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer multiplication of the operands as interpreted
  // by the mode, truncated to the product width.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint px, py, p;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    p  = px * py;
    return p[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready_f_out = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic is, input logic [15:0] iexp);
    int n;
    n = 0;
    a_in = ia; b_in = ib; signed_in = is; valid_f_in = 1'b1;
    @(negedge clk);
    while (!ready_f_in && n < TIMEOUT) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!ready_f_in) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready_f_in=%0b required 1 within %0d cycles", ready_f_in, TIMEOUT);
    end else begin
      sb.push_back('{exp: iexp, acc: cyc + 1});
    end
    tick();
  endtask

  // Drop valid and scramble the operand lines; they only matter at accept.
  task automatic idle_in();
    valid_f_in = 1'b0;
    a_in       = 8'($urandom);
    b_in       = 8'($urandom);
    signed_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() > 0 && n < TIMEOUT) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic  prev_v;
    int    last_rise;
    int    b2b_seen;
    item_t it;
    prev_v = 1'b0; last_rise = 0; b2b_seen = 0;
    forever begin
      @(negedge clk);
      if (!b2b_on) b2b_seen = 0;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (valid_f_out && !prev_v) begin
          if (sb.size() > 0) begin
            checks++;
            if (cyc - sb[0].acc != LATENCY) begin
              errors++;
              $display("FAIL latency got %0d required %0d", cyc - sb[0].acc, LATENCY);
            end
          end
          if (b2b_on) begin
            if (b2b_seen > 0) begin
              checks++;
              if (cyc - last_rise != SPACING) begin
                errors++;
                $display("FAIL b2b_spacing got %0d required %0d", cyc - last_rise, SPACING);
              end
            end
            b2b_seen++;
          end
          last_rise = cyc;
        end
        if (valid_f_out && ready_f_out) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got %h required no result", result);
          end else begin
            it = sb.pop_front();
            if (result !== it.exp) begin
              errors++;
              $display("FAIL result got %h required %h", result, it.exp);
            end
          end
        end
        prev_v = valid_f_out;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  logic [7:0]  dir_a [9] = '{8'd200, 8'h80, 8'hFD, 8'h7F, 8'h80, 8'hFD, 8'h00, 8'h01, 8'h01};
  logic [7:0]  dir_b [9] = '{8'd150, 8'h80, 8'h05, 8'h80, 8'h80, 8'h05, 8'hFF, 8'hFF, 8'hFF};
  logic        dir_s [9] = '{1'b0,   1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [15:0] dir_e [9] = '{16'h7530, 16'h4000, 16'hFFF1, 16'hC080, 16'h4000,
                             16'h04F1, 16'h0000, 16'hFFFF, 16'h00FF};

  initial begin : driver
    logic [7:0] ra, rb;
    logic       rs;
    rst_n = 1'b0; a_in = '0; b_in = '0; signed_in = 1'b0;
    valid_f_in = 1'b0; ready_f_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_in",  {15'd0, ready_f_in},  16'h0001);
    chk("reset_valid_out", {15'd0, valid_f_out}, 16'h0000);
    chk("reset_result",    result,               16'h0000);
    rst_n = 1'b1;
    tick();

    // Directed products: unsigned, signed corners, zero and one.
    for (int i = 0; i < 9; i++) begin
      issue(dir_a[i], dir_b[i], dir_s[i], dir_e[i]);
      idle_in();
      wait_empty();
    end

    // Backpressure: result must hold while downstream stalls.
    ready_f_out = 1'b0;
    issue(8'd200, 8'd150, 1'b0, 16'h7530);
    idle_in();
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!valid_f_out && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_out", {15'd0, valid_f_out}, 16'h0001);
      chk("bp_result",    result,               16'h7530);
      chk("bp_ready_in",  {15'd0, ready_f_in},  16'h0000);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready_f_out = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_consumed_valid_out", {15'd0, valid_f_out}, 16'h0000);
    wait_empty();

    // Back-to-back with valid and ready held high.
    b2b_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'(i % 2);
      issue(ra, rb, rs, ref_mul(ra, rb, rs));
    end
    idle_in();
    wait_empty();
    tick();
    b2b_on = 1'b0;

    // Reset in the middle of a multiplication.
    issue(8'd200, 8'd150, 1'b0, 16'h7530);
    idle_in();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_in",  {15'd0, ready_f_in},  16'h0001);
    chk("midrst_valid_out", {15'd0, valid_f_out}, 16'h0000);
    chk("midrst_result",    result,               16'h0000);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'd3, 8'd7, 1'b0, 16'h0015);
    idle_in();
    wait_empty();

    // Random operands, modes, gaps and downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, ref_mul(ra, rb, rs));
      if ($urandom_range(0, 1) == 1) begin
        idle_in();
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    idle_in();
    rand_rdy = 1'b0;
    ready_f_out = 1'b1;
    wait_empty();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
